csa_resolver: RTL and testbench
===============================

// Module: csa_resolver
// PURPOSE
//  Converts a carry-save pair (s, cout) from the 16-bit CSA stage into a plain binary sum.
//  Result = s + (cout << 1), exact, WIDTH+2 bits wide.
//  Uses a multi-cycle, slice-serial carry-propagate add: one SLICE-bit slice per clock, ripple carry held in a register.
//  Sits downstream of csa_adder; input and output each use a valid/ready handshake.
// PARAMETERS
//  WIDTH  16  width of s_in and c_in
//  SLICE   6  bits resolved per cycle; SLICE must divide WIDTH+2 (NSLICE = (WIDTH+2)/SLICE = 3)
// PORTS
//  clk        input   1          rising-edge clock; single clock domain
//  rst_n      input   1          synchronous reset, active-low (sampled on clk rising edge only)
//  in_valid   input   1          s_in/c_in hold a valid carry-save pair
//  in_ready   output  1          block can accept a pair
//  s_in       input   WIDTH      partial-sum vector
//  c_in       input   WIDTH      carry vector; weight 2^(i+1) for bit i
//  out_valid  output  1          sum_out holds a result
//  out_ready  input   1          consumer accepts the result
//  sum_out    output  WIDTH+2    binary result s_in + {c_in,1'b0}
//  busy       output  1          high in CALC or DONE
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE, in_ready=1, out_valid=0, busy=0.
//   - sum_out=0, slice index=0, carry=0.
//   - Reset wins over every other event, in any state, including mid-CALC; the partial result is discarded.
//  Operand extension:
//   - A = {2'b00, s_in}, B = {1'b0, c_in, 1'b0}, both WIDTH+2 bits.
//   - Both are captured into internal registers on acceptance.
//  FSM:
//   - IDLE: in_ready=1.
//     - in_valid=1 at an edge -> capture A/B, clear carry, k=0, go to CALC.
//   - CALC: in_ready=0.
//     - Each edge: {carry, sum_out[k*SLICE +: SLICE]} <= A_slice + B_slice + carry; k <= k+1.
//     - After the edge that processes k=NSLICE-1 -> DONE.
//   - DONE: out_valid=1; sum_out is stable.
//     - out_ready=1 at an edge -> IDLE, out_valid=0.
//     - out_ready=0 -> hold indefinitely.
//  Timing and throughput:
//   - Acceptance at edge T0: slices are processed at T1..TNSLICE, and out_valid is high after TNSLICE (latency NSLICE = 3 cycles).
//   - in_ready depends on state only; no combinational in->out path.
//   - One transaction per NSLICE+2 cycles minimum. A new pair is not accepted in the same edge as the output handshake; the next acceptance is the following edge in IDLE.
//  Output content:
//   - sum_out upper slices may show the previous result or zeros during CALC; consumers sample only when out_valid=1.
//   - Final carry out of the top slice is always 0 (result fits WIDTH+2); assert this in simulation.
//  Other rules:
//   - in_valid while in CALC/DONE is ignored; the source holds until in_ready.
// TESTING
//  1. s_in=0, c_in=0, one pair -> out_valid exactly 3 cycles after acceptance, sum_out=18'h00000.
//  2. s_in=16'hFFFF, c_in=16'hFFFF -> sum_out=18'h2FFFD (max value, checks top-slice carry).
//  3. CSA pair from a=1, b=2, c=3 (s_in=16'h0000, c_in=16'h0003) -> sum_out=18'h00006.
//  4. Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> sum_out stable, in_ready=0, no second capture; release -> IDLE, then next pair accepted.
//  5. Reset mid-CALC (rst_n=0 for 1 edge after slice 1) -> next cycle in_ready=1, out_valid=0, sum_out=0; the following pair 16'h1234/16'h0001 gives 18'h01236.
//  6. Random: 500 triples a,b,c as {$random}%65535, compressed by a bench CSA model -> sum_out == a+b+c (18-bit) every transaction.

Source files
------------

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair into a binary sum using a slice-serial ripple add.
module csa_resolver #(
  parameter int WIDTH = 16,
  parameter int SLICE = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   s_in,
  input  logic [WIDTH-1:0]   c_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   sum_out,
  output logic               busy
);
  localparam int W      = WIDTH + 2;
  localparam int NSLICE = W / SLICE;
  localparam int KW     = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [KW-1:0] k_q, k_d;
  logic carry_q, carry_d;
  logic [SLICE:0] slice_sum;
  logic last;
  assign last = k_q == KW'(NSLICE - 1);
  assign slice_sum = {1'b0, a_q[k_q*SLICE +: SLICE]} + {1'b0, b_q[k_q*SLICE +: SLICE]}
                   + {{SLICE{1'b0}}, carry_q};
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (in_valid ? CALC : IDLE)
            : state_q == CALC ? (last ? DONE : CALC)
            : (out_ready ? IDLE : DONE);
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
  end
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = {2'b00, s_in};
      b_d     = {1'b0, c_in, 1'b0};
      k_d     = '0;
      carry_d = 1'b0;
    end else if (state_q == CALC) begin
      sum_d[k_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      carry_d = slice_sum[SLICE];
      k_d     = last ? '0 : k_q + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
    end
  // the extended operands always fit W bits, so the top slice never carries out
  always_ff @(posedge clk)
    if (rst_n && state_q == CALC && last)
      assert (!slice_sum[SLICE]) else $error("top slice carry out");
  assign sum_out = sum_q;
endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed and random checks of csa_resolver against an arithmetic reference.
module tb_csa_resolver;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] s_in, c_in;
  logic [17:0] sum_out;
  int n_assert = 0;
  int n_fail = 0;
  csa_resolver dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .busy(busy)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [15:0] s, input logic [15:0] c);
    s_in = s;
    c_in = c;
    in_valid = 1'b1;
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_calc", 32'(in_ready), 32'd0);
    chk("busy_calc", 32'(busy), 32'd1);
  endtask
  task automatic wait_result(input logic [17:0] exp, input string tag);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("latency", 32'(out_valid), 32'(i == 3));
    end
    chk(tag, 32'(sum_out), 32'(exp));
    chk("busy_done", 32'(busy), 32'd1);
  endtask
  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    chk("busy_after_hs", 32'(busy), 32'd0);
  endtask
  initial begin
    logic [17:0] held, exp;
    logic [15:0] a, b, c, s, cy;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    s_in = '0;
    c_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h0000, 16'h0000);
    wait_result(18'h00000, "zero_sum");
    drain();
    send(16'hFFFF, 16'hFFFF);
    wait_result(18'h2FFFD, "max_sum");
    drain();
    send(16'h0000, 16'h0003);
    wait_result(18'h00006, "csa_123");
    drain();
    send(16'h00FF, 16'h0F00);
    wait_result(18'h000FF + 18'h01E00, "bp_first");
    held = 18'h000FF + 18'h01E00;
    s_in = 16'hABCD;
    c_in = 16'h1111;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_sum_stable", 32'(sum_out), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_accept", 32'(in_ready), 32'd0);
    wait_result(18'hABCD + 18'h02222, "bp_second");
    drain();
    send(16'hFFFF, 16'h8000);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    send(16'h1234, 16'h0001);
    wait_result(18'h01236, "after_reset");
    drain();
    for (int t = 0; t < 500; t++) begin
      a = 16'($urandom % 65535);
      b = 16'($urandom % 65535);
      c = 16'($urandom % 65535);
      s = a ^ b ^ c;
      cy = (a & b) | (a & c) | (b & c);
      exp = 18'(int'(a) + int'(b) + int'(c));
      send(s, cy);
      wait_result(exp, "random_sum");
      drain();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
